// File: rtl/imem_loader.sv
// Run-time loadable instruction memory: byte-serial loader plus a registered one-cycle fetch port.
// Optional IMEM_FAULT_EN flags misaligned or out-of-range fetches and returns a NOP for them.
module imem_loader #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic [7:0]               load_byte,
  input  logic                     load_done,
  output logic [$clog2(DEPTH):0]   loaded_words,
  input  logic                     fetch_valid,
  input  logic [ADDR_W-1:0]        fetch_addr,
  output logic                     fetch_ready,
  output logic [DATA_W-1:0]        instr,
  output logic                     instr_valid,
  output logic                     fault
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = $clog2(BYTES) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_LOAD
  } state_t;

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   shift_reg, shift_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [PTR_W-1:0]    ptr_reg, ptr_next;
  logic                wr_en;
  logic [DATA_W-1:0]   wr_data;
  logic [IDX_W-1:0]    wr_idx;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [DATA_W-1:0]   instr_reg;
  logic                instr_valid_reg;
  logic                accept;
  logic [IDX_W-1:0]    rd_idx;
  logic                bad_fetch;

  // Loader FSM and byte assembly; the pointer doubles as the saturating word count.
  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    cnt_next   = cnt_reg;
    ptr_next   = ptr_reg;
    wr_en      = 1'b0;
    wr_data    = (shift_reg << 8) | DATA_W'(load_byte);
    wr_idx     = ptr_reg[IDX_W-1:0];
    case (state_reg)
      ST_IDLE: state_next = ST_RUN;
      ST_RUN: begin
        if (load_start) begin
          state_next = ST_LOAD;
          ptr_next   = '0;
          cnt_next   = '0;
          shift_next = '0;
        end
      end
      ST_LOAD: begin
        if (load_start) begin
          ptr_next   = '0;
          cnt_next   = '0;
          shift_next = '0;
        end else if (load_done) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end else if (load_valid && (ptr_reg != PTR_W'(DEPTH))) begin
          shift_next = wr_data;
          if (cnt_reg == CNT_W'(BYTES - 1)) begin
            wr_en    = 1'b1;
            ptr_next = ptr_reg + 1'b1;
            cnt_next = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign fetch_ready  = (state_reg == ST_RUN);
  assign accept       = fetch_valid && fetch_ready;
  assign rd_idx       = fetch_addr[OFF_W +: IDX_W];
  assign loaded_words = ptr_reg;
  assign instr        = instr_reg;
  assign instr_valid  = instr_valid_reg;

`ifdef IMEM_FAULT_EN
  logic misaligned;
  logic out_of_range;
  logic fault_reg;

  generate
    if (OFF_W > 0) begin : g_align
      assign misaligned = |fetch_addr[OFF_W-1:0];
    end else begin : g_no_align
      assign misaligned = 1'b0;
    end
    if (ADDR_W > OFF_W + IDX_W) begin : g_range
      assign out_of_range = |fetch_addr[ADDR_W-1:OFF_W+IDX_W];
    end else begin : g_no_range
      assign out_of_range = 1'b0;
    end
  endgenerate

  assign bad_fetch = misaligned || out_of_range;
  assign fault     = fault_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_reg <= 1'b0;
    end else if (accept) begin
      fault_reg <= bad_fetch;
    end
  end
`else
  logic addr_unused;

  // Offset and high address bits are deliberately ignored; the index wraps.
  assign addr_unused = ^fetch_addr;
  assign bad_fetch   = 1'b0;
  assign fault       = 1'b0;
`endif

  // Storage has no reset so it maps onto block RAM; contents survive a reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      shift_reg       <= '0;
      cnt_reg         <= '0;
      ptr_reg         <= '0;
      instr_reg       <= '0;
      instr_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      shift_reg       <= shift_next;
      cnt_reg         <= cnt_next;
      ptr_reg         <= ptr_next;
      instr_valid_reg <= accept;
      if (accept) begin
        instr_reg <= bad_fetch ? '0 : mem[rd_idx];
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a DEPTH=64 instance for load/fetch/reset and a DEPTH=4 instance for overflow.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;

  logic        load_start, load_valid, load_done, fetch_valid;
  logic [7:0]  load_byte;
  logic [31:0] fetch_addr;
  logic [6:0]  loaded_words;
  logic        fetch_ready, instr_valid, fault;
  logic [31:0] instr;

  logic        l4_start, l4_valid, l4_done, f4_valid;
  logic [7:0]  l4_byte;
  logic [31:0] f4_addr;
  logic [2:0]  lw4;
  logic        ready4, iv4, fault4;
  logic [31:0] instr4;

  int n_cmp  = 0;
  int n_fail = 0;

  imem_loader #(.DATA_W(32), .DEPTH(64), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte), .load_done(load_done),
    .loaded_words(loaded_words),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .instr(instr), .instr_valid(instr_valid), .fault(fault)
  );

  imem_loader #(.DATA_W(32), .DEPTH(4), .ADDR_W(32)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .load_start(l4_start), .load_valid(l4_valid), .load_byte(l4_byte), .load_done(l4_done),
    .loaded_words(lw4),
    .fetch_valid(f4_valid), .fetch_addr(f4_addr), .fetch_ready(ready4),
    .instr(instr4), .instr_valid(iv4), .fault(fault4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-18s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b);
    load_valid = 1'b1;
    load_byte  = b;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic send4(input logic [7:0] b);
    l4_valid = 1'b1;
    l4_byte  = b;
    tick();
    l4_valid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_valid = 1'b1;
    fetch_addr  = a;
    tick();
  endtask

  task automatic fetch4(input logic [31:0] a);
    f4_valid = 1'b1;
    f4_addr  = a;
    tick();
  endtask

  task automatic pulse_start;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic pulse_done;
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    load_start = 0; load_valid = 0; load_done = 0; load_byte = 0;
    fetch_valid = 0; fetch_addr = 0;
    l4_start = 0; l4_valid = 0; l4_done = 0; l4_byte = 0; f4_valid = 0; f4_addr = 0;
    tick(); tick();
    check("rst_instr", instr, 32'h0);
    check("rst_ivalid", 32'(instr_valid), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_lw", 32'(loaded_words), 32'h0);
    check("rst_ready_idle", 32'(fetch_ready), 32'h0);

    rst_n = 1'b1;
    tick(); tick();
    check("run_ready", 32'(fetch_ready), 32'h1);
    check("run_ivalid", 32'(instr_valid), 32'h0);
    check("run_lw", 32'(loaded_words), 32'h0);

    // Two words.
    pulse_start();
    check("load_ready", 32'(fetch_ready), 32'h0);
    send(8'h20); send(8'h08); send(8'h00); send(8'h20);
    send(8'h20); send(8'h09); send(8'h00); send(8'h27);
    check("lw_two", 32'(loaded_words), 32'd2);
    pulse_done();
    check("done_ready", 32'(fetch_ready), 32'h1);

    fetch(32'h0);
    check("b2b_w0", instr, 32'h20080020);
    check("b2b_v0", 32'(instr_valid), 32'h1);
    fetch(32'h4);
    check("b2b_w1", instr, 32'h20090027);
    check("b2b_v1", 32'(instr_valid), 32'h1);
    fetch_valid = 1'b0;
    tick();
    check("idle_ivalid", 32'(instr_valid), 32'h0);

    // Fetch accepted alongside load_start still completes.
    fetch_valid = 1'b1;
    fetch_addr  = 32'h0;
    load_start  = 1'b1;
    tick();
    load_start  = 1'b0;
    check("start_fetch", instr, 32'h20080020);
    check("start_fvalid", 32'(instr_valid), 32'h1);
    check("start_ready", 32'(fetch_ready), 32'h0);
    tick();
    check("load_ivalid", 32'(instr_valid), 32'h0);
    fetch_valid = 1'b0;

    // Partial word discarded.
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD); send(8'h11); send(8'h22);
    check("partial_lw", 32'(loaded_words), 32'd1);
    pulse_done();
    check("partial_lw_done", 32'(loaded_words), 32'd1);
    fetch(32'h4);
    check("partial_w1", instr, 32'h20090027);
    fetch(32'h0);
    check("partial_w0", instr, 32'hAABBCCDD);
    fetch_valid = 1'b0;

    // Restart mid-stream.
    pulse_start();
    send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05);
    check("restart_lw_pre", 32'(loaded_words), 32'd1);
    pulse_start();
    check("restart_lw_zero", 32'(loaded_words), 32'd0);
    send(8'h10); send(8'h20); send(8'h30); send(8'h40);
    check("restart_lw_one", 32'(loaded_words), 32'd1);
    pulse_done();
    fetch(32'h0);
    check("restart_w0", instr, 32'h10203040);
    fetch(32'h4);
    check("restart_w1", instr, 32'h20090027);

    // Misaligned / out-of-range fetches.
    fetch(32'h2);
`ifdef IMEM_FAULT_EN
    check("mis_instr", instr, 32'h0);
    check("mis_fault", 32'(fault), 32'h1);
`else
    check("mis_instr", instr, 32'h10203040);
    check("mis_fault", 32'(fault), 32'h0);
`endif
    fetch(32'h100);
`ifdef IMEM_FAULT_EN
    check("oor_instr", instr, 32'h0);
    check("oor_fault", 32'(fault), 32'h1);
`else
    check("oor_instr", instr, 32'h10203040);
    check("oor_fault", 32'(fault), 32'h0);
`endif
    fetch(32'h0);
    check("ok_instr", instr, 32'h10203040);
    check("ok_fault", 32'(fault), 32'h0);
    fetch(32'h104);
`ifdef IMEM_FAULT_EN
    check("oor1_instr", instr, 32'h0);
`else
    check("oor1_instr", instr, 32'h20090027);
`endif
    fetch_valid = 1'b0;
    tick();

    // Overflow on the DEPTH=4 instance.
    l4_start = 1'b1;
    tick();
    l4_start = 1'b0;
    for (int k = 0; k < 16; k++) send4(8'(k));
    check("ovf_lw16", 32'(lw4), 32'd4);
    for (int k = 16; k < 20; k++) send4(8'(k));
    check("ovf_lw20", 32'(lw4), 32'd4);
    l4_done = 1'b1;
    tick();
    l4_done = 1'b0;
    fetch4(32'h0);
    check("ovf_w0", instr4, 32'h00010203);
    fetch4(32'hC);
    check("ovf_w3", instr4, 32'h0C0D0E0F);
    fetch4(32'h10);
`ifdef IMEM_FAULT_EN
    check("ovf_wrap", instr4, 32'h0);
    check("ovf_wrap_fault", 32'(fault4), 32'h1);
`else
    check("ovf_wrap", instr4, 32'h00010203);
    check("ovf_wrap_fault", 32'(fault4), 32'h0);
`endif
    f4_valid = 1'b0;

    // Reset during LOAD after three words.
    pulse_start();
    send(8'hA0); send(8'hA1); send(8'hA2); send(8'hA3);
    send(8'hB0); send(8'hB1); send(8'hB2); send(8'hB3);
    send(8'hC0); send(8'hC1); send(8'hC2); send(8'hC3);
    send(8'hD0); send(8'hD1);
    check("mid_lw", 32'(loaded_words), 32'd3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_lw", 32'(loaded_words), 32'd0);
    check("mid_rst_ready", 32'(fetch_ready), 32'h0);
    check("mid_rst_instr", instr, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("after_ready", 32'(fetch_ready), 32'h1);
    check("after_lw", 32'(loaded_words), 32'd0);
    fetch(32'h8);
    check("after_w2", instr, 32'hC0C1C2C3);
    fetch(32'h0);
    check("after_w0", instr, 32'hA0A1A2A3);
    fetch(32'h4);
    check("after_w1", instr, 32'hB0B1B2B3);
    fetch_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Parametrised, synchronous instruction memory for the single-cycle/pipelined CPU datapath. It replaces the hard-coded initial-block ROM with a RAM that is filled at run time from a byte-serial load port. It serves fetches through a registered one-cycle read with a valid/ready handshake. It sits between the PC register and the instruction decoder; the loader side connects to a test harness or UART receiver.

## Interface
Parameters:
- DATA_W, 32, instruction width in bits; must be a multiple of 8.
- DEPTH, 64, number of instruction words; power of two, at least 2.
- ADDR_W, 32, width of the byte address from the PC.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle pulse that enters LOAD and clears the write pointer.
- load_valid  in  1  load_byte is valid this cycle.
- load_byte  in  8  load data, most significant byte of each word first.
- load_done  in  1  one-cycle pulse that ends LOAD and returns to RUN.
- loaded_words  out  $clog2(DEPTH)+1  number of complete words written since the last load_start.
- fetch_valid  in  1  fetch request.
- fetch_addr  in  ADDR_W  byte address.
- fetch_ready  out  1  block accepts a request this cycle.
- instr  out  DATA_W  fetched instruction.
- instr_valid  out  1  instr is valid; asserted one cycle after acceptance.
- fault  out  1  fetch was misaligned or out of range (IMEM_FAULT_EN only).

## Operation
- States: IDLE → RUN on the first clock after reset release. RUN → LOAD on load_start. LOAD → RUN on load_done.
- Reset values: state=IDLE, instr=0, instr_valid=0, fault=0, loaded_words=0, byte counter=0, write pointer=0. Memory contents are not reset.
- fetch_ready is 1 only in RUN. In IDLE and LOAD, fetch requests are ignored and instr_valid=0.
- A fetch is accepted when fetch_valid && fetch_ready. The word index is fetch_addr >> log2(DATA_W/8).
- LOAD byte assembly:
  - Each load_valid byte shifts into a DATA_W shift register and increments the byte counter.
  - When the counter reaches DATA_W/8, the assembled word is written at the write pointer. The pointer increments, loaded_words increments, and the counter clears.
- Pointer full: when the write pointer reaches DEPTH, further bytes are dropped and loaded_words saturates at DEPTH.
- load_done with a partial word pending discards the partial bytes; the counter clears.
- load_start while already in LOAD restarts the load: pointer, counter and loaded_words all clear.
- load_start and load_done in the same cycle: load_start wins.
- Any load input outside LOAD is ignored.
- Reset asserted mid-LOAD aborts the load. Words already written stay in memory; loaded_words reads 0.
- Fetch outside a loaded region returns the stored contents, which may be stale. No zero-fill is performed.

## Timing
- Fetch latency is 1 cycle. The request is accepted at edge N. instr and instr_valid are registered at edge N+1.
- Back-to-back fetches, one per cycle, are supported. instr_valid drops the cycle after a cycle with no accepted request.
- Entering LOAD: fetch_ready deasserts in the cycle after the load_start edge. A fetch accepted in the same cycle as load_start still completes. instr_valid is 0 from the following cycle.
- Write-to-read: a word written at edge N is readable by a fetch accepted at edge N+1 or later.
- Leaving LOAD: RUN is entered at the load_done edge; fetch_ready=1 from the next cycle.

## Configuration
- IMEM_FAULT_EN defined:
  - A fetch with nonzero low address bits, or with word index ≥ DEPTH, returns instr=0 (NOP) and fault=1, both with instr_valid.
  - fault clears on the next valid fetch that is in range and aligned.
- IMEM_FAULT_EN undefined:
  - fault is tied to 0.
  - Low address bits are ignored and the word index wraps modulo DEPTH.

## Test plan
- Reset, then 2 cycles: fetch_ready=1, instr_valid=0, loaded_words=0.
- Load two words:
  - Stimulus: load_start, then bytes 20 08 00 20 and 20 09 00 27, then load_done.
  - Required: loaded_words=2.
  - Fetch at addresses 0 and 4 back-to-back returns 0x20080020 then 0x20090027 on consecutive cycles, each 1 cycle after acceptance.
- Partial word and restart:
  - Stimulus: 6 bytes, then load_done.
  - Required: loaded_words=1; address 4 is unchanged.
  - Then load_start mid-stream: loaded_words=0 and the pointer restarts at 0.
- Overflow: DEPTH=4, load 20 bytes → loaded_words=4; word 0 is not overwritten.
- With IMEM_FAULT_EN:
  - Fetch 0x2 → instr=0, fault=1.
  - Fetch 0x100 with DEPTH=64 → instr=0, fault=1.
  - Fetch 0x0 → fault=0.
  - Without the macro, 0x100 returns word 0.
- Reset asserted mid-LOAD after 3 words → state IDLE, loaded_words=0. After the return to RUN, a fetch at address 8 returns the third word.
